// File: rtl/clk_en_synth.sv
// ---------------------------------------------------------------------------
// clk_en_synth
//
// Multi-channel fractional clock-enable synthesiser. Each channel runs an
// ACC_W-bit phase accumulator on REFERENCECLK. The accumulator carry becomes
// a one-cycle enable, so the average enable rate is F_clk * INC / 2^ACC_W.
// Increments can be reprogrammed at runtime. A new value takes effect only
// on an accumulator wrap, which keeps the pulse train glitch-free. Each
// channel also has its own lock flag and a bypass mode.
//
// Ports
//   REFERENCECLK  in   fabric clock, rising edge
//   RESET         in   asynchronous, active-high reset
//   CFG_VALID     in   config request
//   CFG_READY     out  config accept (combinational); low while the target
//                      channel already holds a pending config, or while
//                      RESET is high
//   CFG_CH        in   target channel; out-of-range values are accepted and
//                      ignored
//   CFG_INC       in   new increment
//   BYPASS        in   per-channel bypass (enable every cycle, lock forced)
//   EN_OUT        out  registered one-cycle enables
//   LOCK          out  registered per-channel lock
// ---------------------------------------------------------------------------
module clk_en_synth #(
  parameter int NUM_CH        = 2,
  parameter int ACC_W         = 16,
  parameter int DEFAULT_INC   = 13107,
  parameter int SETTLE_CYCLES = 16,
  localparam int CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              REFERENCECLK,
  input  logic              RESET,
  input  logic              CFG_VALID,
  output logic              CFG_READY,
  input  logic [CH_W-1:0]   CFG_CH,
  input  logic [ACC_W-1:0]  CFG_INC,
  input  logic [NUM_CH-1:0] BYPASS,
  output logic [NUM_CH-1:0] EN_OUT,
  output logic [NUM_CH-1:0] LOCK
);

  localparam int SLOTS = 1 << CH_W;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_SETTLING = 2'd1;
  localparam logic [1:0] ST_LOCKED   = 2'd2;

  localparam logic [ACC_W-1:0] INC_RST   = ACC_W'(DEFAULT_INC);
  localparam logic [1:0]       ST_RST    = (DEFAULT_INC == 0) ? ST_IDLE : ST_SETTLING;
  localparam logic [7:0]       SETTLE_N  = 8'(SETTLE_CYCLES);

  logic [NUM_CH-1:0] pend_valid;
  logic [SLOTS-1:0]  pend_slots;
  logic [NUM_CH-1:0] accept;

  // Unused channel codes read as "not pending", so a config addressed to a
  // non-existent channel is accepted and simply dropped.
  assign pend_slots = SLOTS'(pend_valid);
  assign CFG_READY  = !RESET && !pend_slots[CFG_CH];

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic [ACC_W-1:0] pend_q, pend_d;
    logic             pend_valid_q, pend_valid_d;
    logic [7:0]       settle_q, settle_d;
    logic [1:0]       state_q, state_d;
    logic             bypass_q, bypass_d;
    logic             en_q, en_d;
    logic             lock_q, lock_d;
    logic [ACC_W:0]   sum;
    logic             carry;
    logic             apply;

    assign accept[gi] = CFG_VALID && CFG_READY && (CFG_CH == CH_W'(gi));

    always_comb begin
      sum          = {1'b0, acc_q} + {1'b0, inc_q};
      carry        = sum[ACC_W];
      acc_d        = acc_q;
      inc_d        = inc_q;
      pend_d       = pend_q;
      settle_d     = settle_q;
      state_d      = state_q;
      bypass_d     = BYPASS[gi];
      en_d         = 1'b0;
      apply        = 1'b0;

      if (accept[gi]) begin
        pend_d = CFG_INC;
      end

      if (BYPASS[gi]) begin
        // Phase is frozen and any pending config waits for release.
        en_d = 1'b1;
      end else begin
        acc_d = sum[ACC_W-1:0];
        en_d  = carry;
        // A pending value is only ever visible here on an edge after the
        // one that accepted it. An idle channel (inc==0) never carries, so
        // it takes the new value straight away.
        apply = pend_valid_q && (carry || (inc_q == '0));
        if (apply) begin
          inc_d    = pend_q;
          settle_d = 8'd0;
          state_d  = (pend_q == '0) ? ST_IDLE : ST_SETTLING;
        end else if (bypass_q) begin
          // First edge after bypass release: lock must be re-earned.
          settle_d = 8'd0;
          state_d  = (inc_q == '0) ? ST_IDLE : ST_SETTLING;
        end else if ((state_q == ST_SETTLING) && carry) begin
          settle_d = settle_q + 8'd1;
          if (settle_d == SETTLE_N) begin
            state_d = ST_LOCKED;
          end
        end
      end

      // Acceptance needs pend_valid_q==0 and apply needs it ==1, so the two
      // never happen on the same edge.
      if (accept[gi]) begin
        pend_valid_d = 1'b1;
      end else if (apply) begin
        pend_valid_d = 1'b0;
      end else begin
        pend_valid_d = pend_valid_q;
      end

      lock_d = BYPASS[gi] || (state_d == ST_LOCKED);
    end

    always_ff @(posedge REFERENCECLK or posedge RESET) begin
      if (RESET) begin
        acc_q        <= '0;
        inc_q        <= INC_RST;
        pend_q       <= '0;
        pend_valid_q <= 1'b0;
        settle_q     <= 8'd0;
        state_q      <= ST_RST;
        bypass_q     <= 1'b0;
        en_q         <= 1'b0;
        lock_q       <= 1'b0;
      end else begin
        acc_q        <= acc_d;
        inc_q        <= inc_d;
        pend_q       <= pend_d;
        pend_valid_q <= pend_valid_d;
        settle_q     <= settle_d;
        state_q      <= state_d;
        bypass_q     <= bypass_d;
        en_q         <= en_d;
        lock_q       <= lock_d;
      end
    end

    assign pend_valid[gi] = pend_valid_q;
    assign EN_OUT[gi]     = en_q;
    assign LOCK[gi]       = lock_q;
  end

endmodule

// File: tb/tb_clk_en_synth.sv
// Directed bench for clk_en_synth with ACC_W=8, DEFAULT_INC=51, SETTLE=16.
// Edge numbers in the comments count rising edges after reset release;
// outputs are sampled on the falling edge that follows each rising edge.
module tb_clk_en_synth;
  logic       clk;
  logic       rst;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [0:0] cfg_ch;
  logic [7:0] cfg_inc;
  logic [1:0] bypass;
  logic [1:0] en_out;
  logic [1:0] lock;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int cnt0        = 0;
  int cnt1        = 0;
  int adj0        = 0;
  int nolock1     = 0;
  int lockpulse   = 0;
  bit seen_lock   = 0;
  bit prev0       = 0;

  clk_en_synth #(
    .NUM_CH(2), .ACC_W(8), .DEFAULT_INC(51), .SETTLE_CYCLES(16)
  ) dut (
    .REFERENCECLK(clk),
    .RESET(rst),
    .CFG_VALID(cfg_valid),
    .CFG_READY(cfg_ready),
    .CFG_CH(cfg_ch),
    .CFG_INC(cfg_inc),
    .BYPASS(bypass),
    .EN_OUT(en_out),
    .LOCK(lock)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and update the running observations.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (en_out[0]) cnt0++;
    if (en_out[1]) cnt1++;
    if (prev0 && en_out[0]) adj0++;
    prev0 = en_out[0];
    if (!lock[1]) nolock1++;
    if (!seen_lock && lock[0]) begin
      seen_lock = 1'b1;
      lockpulse = cnt0;
    end
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  initial begin
    rst = 1'b1; cfg_valid = 1'b0; cfg_ch = 1'b0; cfg_inc = 8'h00; bypass = 2'b00;

    // ---- reset held 5 cycles
    repeat (5) @(negedge clk);
    chk("rst_en", 32'(en_out), 32'h0);
    chk("rst_lock", 32'(lock), 32'h0);
    chk("rst_ready", 32'(cfg_ready), 32'h0);
    rst = 1'b0;
    cyc = 0; cnt0 = 0; cnt1 = 0; adj0 = 0; seen_lock = 1'b0; prev0 = 1'b0;

    // ---- default rate: first carry on edge 6 (51*6=306)
    run_to(5);
    chk("t1_en_e5", 32'(en_out[0]), 32'h0);
    step();
    chk("t1_en_e6", 32'(en_out), 32'h3);
    run_to(256);
    chk("t1_cnt0", cnt0, 51);
    chk("t1_cnt1", cnt1, 51);
    chk("t1_adjacent", adj0, 0);
    chk("t1_lock_pulse", lockpulse, 16);
    chk("t1_lock_e256", 32'(lock), 32'h3);

    // ---- ch0 -> 0x80; acc0=0, next ch0 carry on edge 262
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_inc = 8'h80;
    #1 chk("t2_ready_pre", 32'(cfg_ready), 32'h1);
    step();                                   // 257: accepted
    cfg_valid = 1'b0;
    cnt1 = 0; nolock1 = 0;
    #1 chk("t2_ready_held", 32'(cfg_ready), 32'h0);
    run_to(261);
    chk("t2_ready_e261", 32'(cfg_ready), 32'h0);
    chk("t2_en_e261", 32'(en_out[0]), 32'h0);
    step();                                   // 262: apply, acc=50
    chk("t2_en_e262", 32'(en_out[0]), 32'h1);
    chk("t2_lock_e262", 32'(lock[0]), 32'h0);
    chk("t2_ready_e262", 32'(cfg_ready), 32'h1);
    step(); chk("t2_en_e263", 32'(en_out[0]), 32'h0);
    step(); chk("t2_en_e264", 32'(en_out[0]), 32'h1);
    step(); chk("t2_en_e265", 32'(en_out[0]), 32'h0);
    step(); chk("t2_en_e266", 32'(en_out[0]), 32'h1);
    run_to(292);
    chk("t2_lock_e292", 32'(lock[0]), 32'h0);
    run_to(294);
    chk("t2_lock_e294", 32'(lock[0]), 32'h1);
    run_to(512);
    chk("t2_ch1_cnt", cnt1, 51);
    chk("t2_ch1_lock", nolock1, 0);

    // ---- back-to-back configs to ch0; acc0=50, inc 0x80
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_inc = 8'h40;
    #1 chk("t3_ready_a", 32'(cfg_ready), 32'h1);
    step();                                   // 513: first accepted, acc=178
    cfg_inc = 8'h20;
    #1 chk("t3_ready_b", 32'(cfg_ready), 32'h0);
    step();                                   // 514: carry, 0x40 applies, acc=50
    chk("t3_en_e514", 32'(en_out[0]), 32'h1);
    chk("t3_ready_e514", 32'(cfg_ready), 32'h1);
    step();                                   // 515: second accepted, acc=114
    cfg_valid = 1'b0;
    #1 chk("t3_ready_e515", 32'(cfg_ready), 32'h0);
    chk("t3_en_e515", 32'(en_out[0]), 32'h0);
    step(); chk("t3_en_e516", 32'(en_out[0]), 32'h0);
    step(); chk("t3_en_e517", 32'(en_out[0]), 32'h0);
    step();                                   // 518: carry, 0x20 applies, acc=50
    chk("t3_en_e518", 32'(en_out[0]), 32'h1);
    chk("t3_lock_e518", 32'(lock[0]), 32'h0);
    chk("t3_ready_e518", 32'(cfg_ready), 32'h1);
    cnt0 = 0;
    run_to(774);
    chk("t3_cnt0", cnt0, 32);

    // ---- ch1 -> 0 then 0xFF; ch1 next carry at edge 779
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_inc = 8'h00;
    #1 chk("t4_ready_a", 32'(cfg_ready), 32'h1);
    step();                                   // 775
    cfg_valid = 1'b0;
    #1 chk("t4_ready_held", 32'(cfg_ready), 32'h0);
    run_to(778);
    chk("t4_lock1_e778", 32'(lock[1]), 32'h1);
    chk("t4_en1_e778", 32'(en_out[1]), 32'h0);
    step();                                   // 779: apply inc=0, acc1=49
    chk("t4_en1_e779", 32'(en_out[1]), 32'h1);
    chk("t4_lock1_e779", 32'(lock[1]), 32'h0);
    cnt1 = 0;
    run_to(799);
    chk("t4_idle_cnt", cnt1, 0);
    chk("t4_idle_lock", 32'(lock[1]), 32'h0);
    cfg_valid = 1'b1; cfg_ch = 1'b1; cfg_inc = 8'hFF;
    #1 chk("t4_ready_b", 32'(cfg_ready), 32'h1);
    step();                                   // 800: accepted
    cfg_valid = 1'b0;
    #1 chk("t4_ready_e800", 32'(cfg_ready), 32'h0);
    step();                                   // 801: applies from idle
    chk("t4_ready_e801", 32'(cfg_ready), 32'h1);
    chk("t4_en1_e801", 32'(en_out[1]), 32'h0);
    cnt1 = 0;
    run_to(816);
    chk("t4_lock1_e816", 32'(lock[1]), 32'h0);
    step();
    chk("t4_lock1_e817", 32'(lock[1]), 32'h1);
    run_to(850);
    chk("t4_en1_e850", 32'(en_out[1]), 32'h1);
    step();                                   // 851: acc1 0 -> 255, no carry
    chk("t4_en1_e851", 32'(en_out[1]), 32'h0);
    run_to(1057);
    chk("t4_cnt1", cnt1, 255);

    // ---- bypass ch0 for 10 cycles; acc0=146, inc 0x20
    bypass = 2'b01;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t5_byp_en", 32'(en_out[0]), 32'h1);
      chk("t5_byp_lock", 32'(lock[0]), 32'h1);
    end
    bypass = 2'b00;
    step();                                   // 1068: acc 178
    chk("t5_en_e1068", 32'(en_out[0]), 32'h0);
    chk("t5_lock_e1068", 32'(lock[0]), 32'h0);
    chk("t5_lock1_e1068", 32'(lock[1]), 32'h1);
    step(); chk("t5_en_e1069", 32'(en_out[0]), 32'h0);
    step(); chk("t5_en_e1070", 32'(en_out[0]), 32'h0);
    step(); chk("t5_en_e1071", 32'(en_out[0]), 32'h1);
    run_to(1183);
    chk("t5_lock_e1183", 32'(lock[0]), 32'h0);
    run_to(1191);
    chk("t5_lock_e1191", 32'(lock[0]), 32'h1);
    chk("t5_en_e1191", 32'(en_out[0]), 32'h1);

    // ---- reset mid-pulse with a pending ch0 config
    cfg_valid = 1'b1; cfg_ch = 1'b0; cfg_inc = 8'h80;
    step();                                   // 1192: accepted
    cfg_valid = 1'b0;
    #1 chk("t6_ready_pend", 32'(cfg_ready), 32'h0);
    step();                                   // 1193
    chk("t6_en1_pre", 32'(en_out[1]), 32'h1);
    #2 rst = 1'b1;
    #1 chk("t6_rst_en", 32'(en_out), 32'h0);
    chk("t6_rst_lock", 32'(lock), 32'h0);
    chk("t6_rst_ready", 32'(cfg_ready), 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    cyc = 0; cnt0 = 0; seen_lock = 1'b0; prev0 = 1'b0; lockpulse = 0;
    #1 chk("t6_ready_post", 32'(cfg_ready), 32'h1);
    run_to(256);
    chk("t6_cnt0", cnt0, 51);
    chk("t6_lock_pulse", lockpulse, 16);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
